// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation in flight at a time: IDLE grants, EXEC captures the ALU output, DONE holds it until acked.
module alu_arbiter #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [OPERAND_SIZE-1:0] req0_operand1,
  input  logic [OPERAND_SIZE-1:0] req0_operand2,
  output logic                    req0_ready,
  output logic                    resp0_valid,
  output logic [OPERAND_SIZE-1:0] resp0_result,
  output logic                    resp0_zero,
  input  logic                    resp0_ack,
  input  logic                    req1_valid,
  input  logic [OPERAND_SIZE-1:0] req1_operand1,
  input  logic [OPERAND_SIZE-1:0] req1_operand2,
  output logic                    req1_ready,
  output logic                    resp1_valid,
  output logic [OPERAND_SIZE-1:0] resp1_result,
  output logic                    resp1_zero,
  input  logic                    resp1_ack,
  output logic [OPERAND_SIZE-1:0] alu_operand1,
  output logic [OPERAND_SIZE-1:0] alu_operand2,
  input  logic [OPERAND_SIZE-1:0] alu_result,
  input  logic                    alu_zero,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [OPERAND_SIZE-1:0] op1_q, op1_d;
  logic [OPERAND_SIZE-1:0] op2_q, op2_d;
  logic [OPERAND_SIZE-1:0] result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    any_req;
  logic                    pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    result_d     = result_q;
    zero_d       = zero_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    any_req = req0_valid | req1_valid;
    // On a tie the requester that was not served last wins; otherwise the lone requester wins.
    pick    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

    case (state_q)
      IDLE: begin
        if (any_req && !reset) begin
          req0_ready = ~pick;
          req1_ready = pick;
          grant_d    = pick;
          op1_d      = pick ? req1_operand1 : req0_operand1;
          op2_d      = pick ? req1_operand2 : req0_operand2;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = DONE;
      end
      DONE: begin
        if (grant_q ? resp1_ack : resp0_ack) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU sees only latched operands, never the live requester inputs.
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;

  assign busy         = (state_q != IDLE);
  assign resp0_valid  = (state_q == DONE) && !grant_q;
  assign resp1_valid  = (state_q == DONE) && grant_q;
  assign resp0_result = grant_q ? '0 : result_q;
  assign resp0_zero   = grant_q ? 1'b0 : zero_q;
  assign resp1_result = grant_q ? result_q : '0;
  assign resp1_zero   = grant_q ? zero_q : 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an adder stands in for the shared ALU; a transaction-level model predicts grants and results.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero, busy;
  logic [W-1:0] resp0_result, resp1_result, alu_operand1, alu_operand2, alu_result;
  logic         alu_zero;

  int total = 0;
  int bad = 0;
  int mdl_last = 1;

  always #5 clk = ~clk;

  assign alu_result = alu_operand1 + alu_operand2;
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.OPERAND_SIZE(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_operand1(a0), .req0_operand2(b0), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_ack(ack0),
    .req1_valid(v1), .req1_operand1(a1), .req1_operand2(b1), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_ack(ack1),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Reference grant rule: -1 none, otherwise the requester index.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return 1 - mdl_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mdl_last = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; v0 = 1'b1; v1 = 1'b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if ({req0_ready, req1_ready, busy, resp0_valid, resp1_valid} !== 5'b0) begin
        bad++; $display("FAIL reset_ctrl: got %b want 00000", {req0_ready, req1_ready, busy, resp0_valid, resp1_valid});
      end
      total++;
      if ({alu_operand1, alu_operand2, resp0_result, resp1_result, resp0_zero, resp1_zero} !== '0) begin
        bad++; $display("FAIL reset_data: op1=%h op2=%h r0=%h r1=%h want all zero", alu_operand1, alu_operand2, resp0_result, resp1_result);
      end
    end
    @(negedge clk);
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    mdl_last = 1;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    v0 = 1'b1; a0 = 1; b0 = 0; v1 = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    v0 = 1'b0; a0 = $urandom; b0 = $urandom;
    #1;
    total++;
    if ({busy, resp0_valid, resp1_valid} !== 3'b100) begin bad++; $display("FAIL single_exec: got %b want 100", {busy, resp0_valid, resp1_valid}); end
    total++;
    if ({alu_operand1, alu_operand2} !== {32'd1, 32'd0}) begin bad++; $display("FAIL single_aluops: got %h/%h want 1/0", alu_operand1, alu_operand2); end
    @(negedge clk); #1;
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b10) begin bad++; $display("FAIL single_valid: got %b want 10", {resp0_valid, resp1_valid}); end
    total++;
    if (resp0_result !== 32'd1 || resp0_zero !== 1'b0) begin bad++; $display("FAIL single_result: got %h z=%b want 1 z=0", resp0_result, resp0_zero); end
    total++;
    if (resp1_result !== '0 || resp1_zero !== 1'b0) begin bad++; $display("FAIL single_other: got %h z=%b want 0 z=0", resp1_result, resp1_zero); end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    mdl_last = 0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_tie();
    int w;
    logic [W-1:0] es;
    int want[3] = '{0, 1, 0};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ack0 = 1'b0; ack1 = 1'b0; v0 = 1'b1; v1 = 1'b1;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      w = pick(1'b1, 1'b1);
      es = (w == 0) ? a0 + b0 : a1 + b1;
      #1;
      total++;
      if (w != want[k]) begin bad++; $display("FAIL tie_model_%0d: got %0d want %0d", k, w, want[k]); end
      total++;
      if ({req0_ready, req1_ready} !== ((want[k] == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL tie_grant_%0d: got %b want req%0d", k, {req0_ready, req1_ready}, want[k]);
      end
      @(negedge clk); #1;
      total++;
      if ({busy, req0_ready, req1_ready} !== 3'b100) begin bad++; $display("FAIL tie_exec_%0d: got %b want 100", k, {busy, req0_ready, req1_ready}); end
      @(negedge clk); #1;
      total++;
      if ({resp0_valid, resp1_valid} !== ((w == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL tie_valid_%0d: got %b want req%0d", k, {resp0_valid, resp1_valid}, w);
      end
      total++;
      if (((w == 0) ? resp0_result : resp1_result) !== es) begin
        bad++; $display("FAIL tie_result_%0d: got %h want %h", k, (w == 0) ? resp0_result : resp1_result, es);
      end
      if (w == 0) ack0 = 1'b1; else ack1 = 1'b1;
      mdl_last = w;
    end
    @(negedge clk);
    ack0 = 1'b0; ack1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] es;
    @(negedge clk);
    v1 = 1'b1; a1 = $urandom; b1 = $urandom; v0 = 1'b0;
    es = a1 + b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_grant: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    v1 = 1'b0;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      a0 = $urandom; a1 = $urandom;
      #1;
      total++;
      if ({resp1_valid, resp0_valid, req0_ready, req1_ready} !== 4'b1000) begin
        bad++; $display("FAIL bp_hold_ctrl_%0d: got %b want 1000", h, {resp1_valid, resp0_valid, req0_ready, req1_ready});
      end
      total++;
      if (resp1_result !== es || resp1_zero !== (es == '0)) begin
        bad++; $display("FAIL bp_hold_data_%0d: got %h z=%b want %h z=%b", h, resp1_result, resp1_zero, es, es == '0);
      end
      if (h == 5) ack1 = 1'b1;
    end
    @(negedge clk);
    ack1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    mdl_last = 1;
  endtask

  task automatic test_zero();
    logic [W-1:0] pa[2] = '{32'd0, 32'd0};
    logic [W-1:0] pb[2] = '{32'd0, 32'd1};
    logic ez[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ack1 = 1'b0; v1 = 1'b1; a1 = pa[k]; b1 = pb[k];
      #1;
      total++;
      if (req1_ready !== 1'b1) begin bad++; $display("FAIL zero_grant_%0d: got %b want 1", k, req1_ready); end
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk); #1;
      total++;
      if (resp1_valid !== 1'b1 || resp1_zero !== ez[k] || resp1_result !== pa[k] + pb[k]) begin
        bad++; $display("FAIL zero_flag_%0d: got v=%b z=%b r=%h want v=1 z=%b r=%h", k, resp1_valid, resp1_zero, resp1_result, ez[k], pa[k] + pb[k]);
      end
      ack1 = 1'b1;
      mdl_last = 1;
    end
    @(negedge clk);
    ack1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] es;
    @(negedge clk);
    v0 = 1'b1; a0 = $urandom; b0 = $urandom;
    @(negedge clk);
    v0 = 1'b0; reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_exec: busy got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b0;
    mdl_last = 1;
    #1;
    total++;
    if ({busy, resp0_valid, resp1_valid} !== 3'b000 || resp0_result !== '0) begin
      bad++; $display("FAIL rmid_abort: got %b r0=%h want 000 r0=0", {busy, resp0_valid, resp1_valid}, resp0_result);
    end
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    es = a0 + b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rmid_tie: got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk); #1;
    total++;
    if (resp0_valid !== 1'b1 || resp0_result !== es) begin bad++; $display("FAIL rmid_result: got v=%b r=%h want v=1 r=%h", resp0_valid, resp0_result, es); end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    mdl_last = 0;
  endtask

  task automatic test_stray_ack();
    logic [W-1:0] es;
    @(negedge clk);
    ack0 = 1'b1; ack1 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0; ack1 = 1'b0; v1 = 1'b1; a1 = $urandom; b1 = $urandom;
    es = a1 + b1;
    #1;
    total++;
    if ({busy, req0_ready, req1_ready} !== 3'b001) begin bad++; $display("FAIL stray_idle: got %b want 001", {busy, req0_ready, req1_ready}); end
    @(negedge clk);
    v1 = 1'b0; ack0 = 1'b1; ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    #1;
    total++;
    if (resp1_valid !== 1'b1 || resp1_result !== es) begin bad++; $display("FAIL stray_exec: got v=%b r=%h want v=1 r=%h", resp1_valid, resp1_result, es); end
    @(negedge clk);
    ack0 = 1'b0;
    #1;
    total++;
    if (resp1_valid !== 1'b1) begin bad++; $display("FAIL stray_other_ack: resp1_valid got %b want 1", resp1_valid); end
    ack1 = 1'b1;
    mdl_last = 1;
    @(negedge clk);
    ack1 = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = $urandom; b0 = $urandom;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== ((pick(1'b1, 1'b1) == 0) ? 2'b10 : 2'b01)) begin
      bad++; $display("FAIL stray_lastgrant: got %b want req%0d", {req0_ready, req1_ready}, pick(1'b1, 1'b1));
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    ack0 = 1'b1;
    mdl_last = 0;
    @(negedge clk);
    ack0 = 1'b0;
  endtask

  task automatic test_random();
    int w, hold;
    logic [W-1:0] ea, eb, es, got;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      ack0 = 1'b0; ack1 = 1'b0;
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      if (t % 7 == 3) begin a0 = 0; b0 = 0; a1 = '1; b1 = 1; end
      w = pick(v0, v1);
      #1;
      total++;
      if ({req0_ready, req1_ready} !== ((w < 0) ? 2'b00 : (w == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rnd_grant_%0d: got %b want %0d", t, {req0_ready, req1_ready}, w);
      end
      if (w >= 0) begin
        ea = (w == 0) ? a0 : a1;
        eb = (w == 0) ? b0 : b1;
        es = ea + eb;
        @(negedge clk);
        v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
        a0 = $urandom; a1 = $urandom;
        ack0 = 1'($urandom_range(0, 1)); ack1 = 1'($urandom_range(0, 1));
        #1;
        total++;
        if ({busy, resp0_valid, resp1_valid, alu_operand1, alu_operand2} !== {3'b100, ea, eb}) begin
          bad++; $display("FAIL rnd_exec_%0d: got b=%b ops=%h/%h want b=1 ops=%h/%h", t, busy, alu_operand1, alu_operand2, ea, eb);
        end
        hold = $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
          @(negedge clk);
          v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
          if (w == 0) begin ack0 = 1'b0; ack1 = 1'($urandom_range(0, 1)); end
          else begin ack1 = 1'b0; ack0 = 1'($urandom_range(0, 1)); end
          #1;
          got = (w == 0) ? resp0_result : resp1_result;
          total++;
          if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== ((w == 0) ? 4'b1000 : 4'b0100)) begin
            bad++; $display("FAIL rnd_done_ctrl_%0d: got %b want req%0d", t, {resp0_valid, resp1_valid, req0_ready, req1_ready}, w);
          end
          total++;
          if (got !== es || ((w == 0) ? resp0_zero : resp1_zero) !== (es == '0) || ((w == 0) ? resp1_result : resp0_result) !== '0) begin
            bad++; $display("FAIL rnd_done_data_%0d: got %h want %h", t, got, es);
          end
          if (h == hold) begin
            if (w == 0) ack0 = 1'b1; else ack1 = 1'b1;
          end
        end
        mdl_last = w;
      end
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded 200000 without summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_stray_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
